adc_spi_capture: RTL and testbench
==================================

Name: adc_spi_capture

Overview:
- SPI-ADC sequencer directly downstream of the ADC_board AXI4-Lite register slave.
- Register bits (start, channel, continuous mode) drive this block. It clocks one 16-bit frame out to an external 8-channel 12-bit ADC (ADC128S-class, SPI mode 0).
- Returns the converted sample, its channel and status flags for the slave to present as read-back registers.

Parameters:
- CLK_DIV, 4: ACLK cycles per SCLK half-period; legal range 2..255.
- FRAME_BITS, 16: SCLK cycles per conversion frame.
- DATA_BITS, 12: sample width, taken from the last DATA_BITS MISO bits of the frame.
- CH_BITS, 3: channel-select width.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle request to start conversion; ignored while busy_o=1.
- cont_i  in  1  continuous mode: re-arm automatically after each frame.
- chan_i  in  CH_BITS  channel, latched when start is accepted and again at each re-arm.
- sample_ack_i  in  1  clears sample_valid_o (register-read side effect).
- clr_overrun_i  in  1  clears overrun_o.
- busy_o  out  1  high from start acceptance until return to IDLE.
- sample_o  out  DATA_BITS  last captured sample.
- sample_chan_o  out  CH_BITS  channel of sample_o.
- sample_valid_o  out  1  level flag: a new sample is unread.
- overrun_o  out  1  sticky: a sample arrived while the previous one was still unread.
- spi_cs_n_o  out  1  chip select, active low.
- spi_sclk_o  out  1  serial clock; idles low.
- spi_mosi_o  out  1  command bit, MSB first.
- spi_miso_i  in  1  ADC data bit.

Behaviour:
- All state updates on rising ACLK; no other clock domains.
- Reset value of every output is 0, except spi_cs_n_o=1. Reset mid-frame aborts on that edge: cs_n high, sclk low, state IDLE, counters 0.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - start_i=1 latches chan_i, loads the TX shift register with {2'b00, chan, 11'b0} (FRAME_BITS total) and goes to SETUP.
  - busy_o and cs_n low take effect in the next cycle.
- SETUP:
  - Lasts CLK_DIV cycles with sclk low and MOSI = TX MSB.
  - Then goes to SHIFT.
- SHIFT:
  - Lasts 2*FRAME_BITS*CLK_DIV cycles; sclk toggles every CLK_DIV cycles, starting with a rising edge.
  - On each sclk rise, spi_miso_i shifts into the RX register (LSB-in).
  - On each sclk fall, TX shifts left and MOSI takes the next bit.
  - After the FRAME_BITS-th fall, goes to HOLD with sclk low.
- HOLD:
  - Lasts CLK_DIV cycles with cs_n high (minimum deselect time).
  - In the first HOLD cycle: sample_o = RX[DATA_BITS-1:0], sample_chan_o = latched chan, sample_valid_o set.
  - At HOLD end: if cont_i=1, latch chan_i, reload TX and go to SETUP; else go to IDLE and drop busy_o.
- start_i during SETUP, SHIFT or HOLD is ignored, with no queuing.
- Deasserting cont_i mid-frame finishes the current frame, then goes to IDLE.
- Frame length at CLK_DIV=4, FRAME_BITS=16: SETUP 4 + SHIFT 128 + HOLD 4 = 136 cycles.
  - cs_n low from cycle T+1 to T+132, where T is the start-acceptance cycle.
  - sample_valid_o rises in cycle T+133.
- sample_valid_o: a new sample sets it and sample_ack_i clears it.
  - New sample and ack in the same cycle: flag stays 1 and no overrun.
- overrun_o sets when a new sample lands while sample_valid_o=1 with no same-cycle ack.
  - sample_o is still overwritten (newest wins).
  - clr_overrun_i clears overrun_o. If clear and a new overrun occur in the same cycle, set wins.
- Counters:
  - Half-period counter width clog2(CLK_DIV).
  - Edge counter width clog2(2*FRAME_BITS+1).
  - No wrap: counters reload at every state entry.

Decomposition:
- Package adc_spi_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD);
  - command-frame field positions (address MSB index FRAME_BITS-3);
  - the clog2-derived counter widths as localparams/functions.
- One sub-module, adc_sclk_gen:
  - enable-gated CLK_DIV divider;
  - emits sclk level, a one-cycle rise strobe, a one-cycle fall strobe, and an edge count;
  - FSM consumes the strobes.

Test Plan:
- Single conversion: CLK_DIV=4, start_i with chan_i=5; model returns 16'h0ABC on MISO. Required:
  - MOSI frame = 16'h2800;
  - cs_n low for exactly 132 cycles, 16 sclk rises;
  - sample_o=12'hABC, sample_chan_o=5;
  - sample_valid_o rises at T+133; busy_o falls at T+137.
- Start while busy: pulse start_i at T+50 with chan_i=2. Required: no second frame, sample_chan_o=5, busy_o drops at T+137.
- Continuous mode: cont_i=1, chan_i changed 0→7 during frame 1; ack each sample. Required:
  - frames back-to-back with cs_n high for exactly 4 cycles between them;
  - frame 2 MOSI = 16'h3800;
  - overrun_o stays 0.
- Overrun: two continuous frames with no ack, then clr_overrun_i. Required:
  - overrun_o=1 after frame 2, with sample_o holding frame 2 data;
  - overrun_o=0 after clear.
  - Ack coinciding with the frame-2 sample cycle: overrun_o stays 0 and sample_valid_o stays 1.
- Reset mid-frame: ARESET asserted at T+70 for 1 cycle. Required:
  - next cycle cs_n=1, sclk=0, busy_o=0, sample_valid_o=0;
  - a subsequent start produces a clean full 136-cycle frame.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared state type, command-frame layout and counter sizing for the SPI ADC sequencer.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } adc_state_e;

  // Command frame is {2'b00, channel, zeros}; the channel field starts below the two leading zeros.
  localparam int CMD_LEAD_ZEROS = 2;

  function automatic int addr_msb(input int frame_bits);
    return frame_bits - 1 - CMD_LEAD_ZEROS;
  endfunction

  function automatic int hp_cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

  function automatic int edge_cnt_w(input int frame_bits);
    return $clog2(2 * frame_bits + 1);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Enable-gated SCLK divider: toggles every CLK_DIV cycles, first toggle is a rise.
module adc_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_i,
  output logic                              sclk_o,
  output logic                              rise_o,
  output logic                              fall_o,
  output logic [edge_cnt_w(FRAME_BITS)-1:0] edge_cnt_o
);

  localparam int HP_W = hp_cnt_w(CLK_DIV);
  localparam int EC_W = edge_cnt_w(FRAME_BITS);

  logic [HP_W-1:0] hp_q, hp_d;
  logic            sclk_q, sclk_d;
  logic [EC_W-1:0] edge_q, edge_d;
  logic            hp_done;

  // Dropping enable clears everything, so each SHIFT entry starts from a known phase.
  always_comb begin
    hp_done = en_i && (hp_q == HP_W'(CLK_DIV - 1));
    hp_d    = hp_q;
    sclk_d  = sclk_q;
    edge_d  = edge_q;
    if (!en_i) begin
      hp_d   = '0;
      sclk_d = 1'b0;
      edge_d = '0;
    end else if (hp_done) begin
      hp_d   = '0;
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
    end else begin
      hp_d = hp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q   <= '0;
      sclk_q <= 1'b0;
      edge_q <= '0;
    end else begin
      hp_q   <= hp_d;
      sclk_q <= sclk_d;
      edge_q <= edge_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_o     = hp_done && !sclk_q;
  assign fall_o     = hp_done && sclk_q;
  assign edge_cnt_o = edge_q;

endmodule

// File: rtl/adc_spi_capture.sv
// SPI mode-0 sequencer for an 8-channel 12-bit ADC: one command frame out, one sample back.
module adc_spi_capture
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int CH_BITS    = 3
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic [CH_BITS-1:0]   chan_i,
  input  logic                 sample_ack_i,
  input  logic                 clr_overrun_i,
  output logic                 busy_o,
  output logic [DATA_BITS-1:0] sample_o,
  output logic [CH_BITS-1:0]   sample_chan_o,
  output logic                 sample_valid_o,
  output logic                 overrun_o,
  output logic                 spi_cs_n_o,
  output logic                 spi_sclk_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i,
  output logic [1:0]           dbg_state_o
);

  localparam int HP_W     = hp_cnt_w(CLK_DIV);
  localparam int EC_W     = edge_cnt_w(FRAME_BITS);
  localparam int ADDR_MSB = addr_msb(FRAME_BITS);

  adc_state_e             state_q, state_d;
  logic [HP_W-1:0]        hp_q, hp_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [DATA_BITS-1:0]   rx_q, rx_d;
  logic [CH_BITS-1:0]     chan_q, chan_d;
  logic                   busy_q, busy_d;
  logic                   cs_n_q, cs_n_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;
  logic [CH_BITS-1:0]     sample_chan_q, sample_chan_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   gen_en;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [EC_W-1:0]        edge_cnt;
  logic                   hp_last;
  logic                   new_sample;
  logic [FRAME_BITS-1:0]  cmd_word;

  assign gen_en = (state_q == ST_SHIFT);

  adc_sclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_sclk_gen (
    .clk        (ACLK),
    .rst        (ARESET),
    .en_i       (gen_en),
    .sclk_o     (spi_sclk_o),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall),
    .edge_cnt_o (edge_cnt)
  );

  always_comb begin
    state_d       = state_q;
    hp_d          = hp_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    chan_d        = chan_q;
    busy_d        = busy_q;
    cs_n_d        = cs_n_q;
    sample_d      = sample_q;
    sample_chan_d = sample_chan_q;
    new_sample    = 1'b0;
    hp_last       = (hp_q == HP_W'(CLK_DIV - 1));
    cmd_word      = '0;
    cmd_word[ADDR_MSB -: CH_BITS] = chan_i;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          chan_d  = chan_i;
          tx_d    = cmd_word;
          hp_d    = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (hp_last) begin
          hp_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Only the last DATA_BITS bits survive in rx, which is exactly the sample field.
        if (sclk_rise) begin
          rx_d = {rx_q[DATA_BITS-2:0], spi_miso_i};
        end
        if (sclk_fall) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          if (edge_cnt == EC_W'(2 * FRAME_BITS - 1)) begin
            state_d       = ST_HOLD;
            cs_n_d        = 1'b1;
            hp_d          = '0;
            new_sample    = 1'b1;
            sample_d      = rx_q;
            sample_chan_d = chan_q;
          end
        end
      end
      ST_HOLD: begin
        if (hp_last) begin
          hp_d = '0;
          if (cont_i) begin
            chan_d  = chan_i;
            tx_d    = cmd_word;
            cs_n_d  = 1'b0;
            state_d = ST_SETUP;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Valid/ack: valid is a level held until an ack; a landing sample beats a same-cycle ack,
    // and that ack counts as having read the previous sample, so no overrun.
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (new_sample) begin
      valid_d = 1'b1;
    end else if (sample_ack_i) begin
      valid_d = 1'b0;
    end
    if (new_sample && valid_q && !sample_ack_i) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      hp_q          <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      chan_q        <= '0;
      busy_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      sample_q      <= '0;
      sample_chan_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      chan_q        <= chan_d;
      busy_q        <= busy_d;
      cs_n_q        <= cs_n_d;
      sample_q      <= sample_d;
      sample_chan_q <= sample_chan_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign busy_o         = busy_q;
  assign sample_o       = sample_q;
  assign sample_chan_o  = sample_chan_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign spi_cs_n_o     = cs_n_q;
  assign spi_mosi_o     = tx_q[FRAME_BITS-1];
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC pin model, vector table, directed corner sequences, random frames.
module tb_adc_spi_capture;
  import adc_spi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start_i, cont_i, sample_ack_i, clr_overrun_i;
  logic [2:0]  chan_i;
  logic        busy_o, sample_valid_o, overrun_o;
  logic [11:0] sample_o;
  logic [2:0]  sample_chan_o;
  logic        spi_cs_n_o, spi_sclk_o, spi_mosi_o;
  logic        spi_miso_i = 1'b0;
  logic [1:0]  dbg_state_o;

  adc_spi_capture dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .start_i        (start_i),
    .cont_i         (cont_i),
    .chan_i         (chan_i),
    .sample_ack_i   (sample_ack_i),
    .clr_overrun_i  (clr_overrun_i),
    .busy_o         (busy_o),
    .sample_o       (sample_o),
    .sample_chan_o  (sample_chan_o),
    .sample_valid_o (sample_valid_o),
    .overrun_o      (overrun_o),
    .spi_cs_n_o     (spi_cs_n_o),
    .spi_sclk_o     (spi_sclk_o),
    .spi_mosi_o     (spi_mosi_o),
    .spi_miso_i     (spi_miso_i),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock / watchdog
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ADC pin model: serves words MSB first, captures MOSI on SCLK rises, measures frame timing.
  logic [15:0] adc_word_q[$];
  logic [15:0] frame_mosi_q[$];
  int          frame_rise_q[$];
  int          frame_low_q[$];
  int          gap_q[$];
  logic [15:0] adc_sh = '0;
  logic [15:0] mosi_cap = '0;
  int          rise_cnt = 0, low_cyc = 0, high_cyc = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge ACLK) begin
    if (prev_cs && !spi_cs_n_o) begin
      adc_sh     = (adc_word_q.size() > 0) ? adc_word_q.pop_front() : 16'h0000;
      spi_miso_i = adc_sh[15];
      mosi_cap   = '0;
      rise_cnt   = 0;
      low_cyc    = 0;
      gap_q.push_back(high_cyc);
    end
    if (!spi_cs_n_o) begin
      low_cyc++;
      if (!prev_sclk && spi_sclk_o) begin
        mosi_cap = {mosi_cap[14:0], spi_mosi_o};
        rise_cnt++;
      end
      if (prev_sclk && !spi_sclk_o) begin
        adc_sh     = adc_sh << 1;
        spi_miso_i = adc_sh[15];
      end
    end
    if (!prev_cs && spi_cs_n_o) begin
      frame_mosi_q.push_back(mosi_cap);
      frame_rise_q.push_back(rise_cnt);
      frame_low_q.push_back(low_cyc);
      high_cyc = 0;
    end
    if (spi_cs_n_o) high_cyc++;
    prev_cs   = spi_cs_n_o;
    prev_sclk = spi_sclk_o;
  end

  // Scoreboard helpers
  logic [14:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cmd_of(input logic [2:0] ch);
    return {2'b00, ch, 11'b0};
  endfunction

  task automatic pop_frame(input string name, input logic [15:0] exp_mosi);
    check({name, "_present"}, 32'(frame_mosi_q.size() > 0), 32'd1);
    if (frame_mosi_q.size() > 0) begin
      check({name, "_mosi"}, 32'(frame_mosi_q.pop_front()), 32'(exp_mosi));
      check({name, "_rises"}, 32'(frame_rise_q.pop_front()), 32'd16);
      check({name, "_cs_low"}, 32'(frame_low_q.pop_front()), 32'd132);
    end
  endtask

  // Driver tasks
  task automatic pulse_ack();
    sample_ack_i = 1'b1;
    @(negedge ACLK);
    sample_ack_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_overrun_i = 1'b1;
    @(negedge ACLK);
    clr_overrun_i = 1'b0;
  endtask

  // Single-shot frame; k = 0 is the cycle after start acceptance (T+1).
  task automatic run_frame(input logic [2:0] ch, input bit poke, output int valid_k, output int busy_k);
    valid_k = -1;
    busy_k  = -1;
    chan_i  = ch;
    start_i = 1'b1;
    @(negedge ACLK);
    for (int k = 0; k < 400; k++) begin
      if (valid_k < 0 && sample_valid_o) valid_k = k;
      if (!busy_o) begin
        busy_k = k;
        break;
      end
      start_i = poke && (k == 49);
      if (poke && k == 49) chan_i = 3'd2;
      else if (k == 0) chan_i = 3'($urandom_range(0, 7));
      @(negedge ACLK);
    end
    start_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  chan;
    logic [15:0] miso;
    logic [15:0] exp_mosi;
    logic [11:0] exp_sample;
  } vec_t;

  vec_t        vecs[4];
  int          vk, bk, nseen, ovr_seen;
  logic        prev_v, exp_valid, exp_overrun;
  logic [2:0]  ch;
  logic [15:0] wa, wb;
  logic [14:0] got;

  initial begin
    ARESET = 1'b1; start_i = 1'b0; cont_i = 1'b0; chan_i = '0;
    sample_ack_i = 1'b0; clr_overrun_i = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("rst_outputs", 32'({busy_o, sample_valid_o, overrun_o, spi_sclk_o, spi_mosi_o}), 32'd0);
    check("rst_sample", 32'({sample_chan_o, sample_o}), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    ARESET = 1'b0;
    @(negedge ACLK);

    // Table-driven single conversions; vector 0 also pokes start_i at T+50.
    vecs[0] = '{3'd5, 16'h0ABC, 16'h2800, 12'hABC};
    vecs[1] = '{3'd0, 16'hFFFF, 16'h0000, 12'hFFF};
    vecs[2] = '{3'd7, 16'h5123, 16'h3800, 12'h123};
    vecs[3] = '{3'd2, 16'hF000, 16'h1000, 12'h000};
    for (int i = 0; i < 4; i++) begin
      adc_word_q.push_back(vecs[i].miso);
      run_frame(vecs[i].chan, (i == 0), vk, bk);
      check("tbl_valid_rise_k", 32'(vk), 32'd132);
      check("tbl_busy_fall_k", 32'(bk), 32'd136);
      check("tbl_sample", 32'(sample_o), 32'(vecs[i].exp_sample));
      check("tbl_sample_chan", 32'(sample_chan_o), 32'(vecs[i].chan));
      check("tbl_overrun", 32'(overrun_o), 32'd0);
      pop_frame("tbl_frame", vecs[i].exp_mosi);
      repeat (20) @(negedge ACLK);
      check("tbl_stays_idle", 32'({busy_o, spi_cs_n_o}), 32'b01);
      check("tbl_no_extra_frame", 32'(frame_mosi_q.size()), 32'd0);
      pulse_ack();
      check("tbl_ack_clears", 32'(sample_valid_o), 32'd0);
    end

    // Random single-shot frames against a frame-level flag model.
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    for (int r = 0; r < 8; r++) begin
      ch = 3'($urandom_range(0, 7));
      wa = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        exp_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        exp_overrun = 1'b0;
      end
      adc_word_q.push_back(wa);
      run_frame(ch, 1'b0, vk, bk);
      if (exp_valid) exp_overrun = 1'b1;
      exp_valid = 1'b1;
      check("rnd_busy_fall_k", 32'(bk), 32'd136);
      check("rnd_sample", 32'(sample_o), 32'(wa[11:0]));
      check("rnd_sample_chan", 32'(sample_chan_o), 32'(ch));
      check("rnd_valid", 32'(sample_valid_o), 32'(exp_valid));
      check("rnd_overrun", 32'(overrun_o), 32'(exp_overrun));
      pop_frame("rnd_frame", cmd_of(ch));
    end
    pulse_ack();
    pulse_clr();

    // Continuous mode, channel 0 -> 7 during frame 1, every sample acked.
    gap_q.delete();
    wa = 16'($urandom);
    wb = 16'($urandom);
    adc_word_q.push_back(wa);
    adc_word_q.push_back(wb);
    exp_q.push_back({3'd0, wa[11:0]});
    exp_q.push_back({3'd7, wb[11:0]});
    nseen = 0; ovr_seen = 0; prev_v = 1'b0;
    cont_i = 1'b1; chan_i = 3'd0; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    for (int k = 0; k < 700 && busy_o; k++) begin
      if (sample_valid_o && !prev_v) begin
        nseen++;
        if (exp_q.size() > 0) begin
          got = {sample_chan_o, sample_o};
          check("cont_sample", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (overrun_o) ovr_seen = 1;
      prev_v = sample_valid_o;
      sample_ack_i = sample_valid_o;
      if (k == 20) chan_i = 3'd7;
      if (k == 200) cont_i = 1'b0;
      @(negedge ACLK);
    end
    sample_ack_i = 1'b0;
    check("cont_ends_idle", 32'(busy_o), 32'd0);
    check("cont_sample_count", 32'(nseen), 32'd2);
    check("cont_overrun", 32'(ovr_seen), 32'd0);
    pop_frame("cont_frame1", 16'h0000);
    pop_frame("cont_frame2", 16'h3800);
    check("cont_gap_present", 32'(gap_q.size()), 32'd2);
    if (gap_q.size() == 2) check("cont_cs_high_gap", 32'(gap_q[1]), 32'd4);

    // Overrun: two continuous frames, nothing acked.
    pulse_ack();
    ch = 3'($urandom_range(0, 7));
    wa = 16'($urandom);
    wb = 16'($urandom);
    adc_word_q.push_back(wa);
    adc_word_q.push_back(wb);
    cont_i = 1'b1; chan_i = ch; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    for (int k = 0; k < 700 && busy_o; k++) begin
      if (k == 200) cont_i = 1'b0;
      @(negedge ACLK);
    end
    check("ovr_ends_idle", 32'(busy_o), 32'd0);
    check("ovr_set", 32'(overrun_o), 32'd1);
    check("ovr_newest_wins", 32'({sample_chan_o, sample_o}), 32'({ch, wb[11:0]}));
    pop_frame("ovr_frame1", cmd_of(ch));
    pop_frame("ovr_frame2", cmd_of(ch));
    pulse_clr();
    check("ovr_cleared", 32'(overrun_o), 32'd0);
    check("ovr_clr_keeps_valid", 32'(sample_valid_o), 32'd1);
    pulse_ack();

    // Ack landing on the same edge as the frame-2 sample.
    wa = 16'($urandom);
    wb = 16'($urandom);
    adc_word_q.push_back(wa);
    adc_word_q.push_back(wb);
    cont_i = 1'b1; chan_i = 3'd4; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    for (int k = 0; k < 700 && busy_o; k++) begin
      if (k == 267) begin
        check("coin_pre_valid", 32'(sample_valid_o), 32'd1);
        check("coin_pre_sample", 32'(sample_o), 32'(wa[11:0]));
      end
      if (k == 268) begin
        check("coin_valid_held", 32'(sample_valid_o), 32'd1);
        check("coin_no_overrun", 32'(overrun_o), 32'd0);
        check("coin_sample", 32'(sample_o), 32'(wb[11:0]));
      end
      sample_ack_i = (k == 267);
      if (k == 200) cont_i = 1'b0;
      @(negedge ACLK);
    end
    sample_ack_i = 1'b0;
    check("coin_ends_idle", 32'(busy_o), 32'd0);
    frame_mosi_q.delete(); frame_rise_q.delete(); frame_low_q.delete();

    // Reset at T+70 with an unread sample pending.
    adc_word_q.push_back(16'h1234);
    chan_i = 3'd3; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    for (int k = 0; k < 69; k++) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("abort_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("abort_sclk", 32'(spi_sclk_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_valid", 32'(sample_valid_o), 32'd0);
    repeat (5) @(negedge ACLK);
    frame_mosi_q.delete(); frame_rise_q.delete(); frame_low_q.delete();
    adc_word_q.delete();
    adc_word_q.push_back(16'h0DEF);
    run_frame(3'd6, 1'b0, vk, bk);
    check("post_valid_rise_k", 32'(vk), 32'd132);
    check("post_busy_fall_k", 32'(bk), 32'd136);
    check("post_sample", 32'({sample_chan_o, sample_o}), 32'({3'd6, 12'hDEF}));
    pop_frame("post_frame", 16'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
